// File: rtl/mux_sched_pkg.sv
// Shared types and helpers for the round-robin mux scheduler.
//   state_e  : scheduler FSM states
//   SEL_W    : select / index width
//   DATA_W   : mux data width
//   PARK_SEL : select value driven when no transfer is in flight
//   rr_next  : round-robin search returning {found, index}
package mux_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        VALID  = 2'd2
    } state_e;

    localparam int                SEL_W    = 5;
    localparam int                DATA_W   = 2;
    localparam logic [SEL_W-1:0]  PARK_SEL = 5'd31;
    localparam int                MAX_REQ  = 31;

    // Search upward from last+1, wrapping after index 'top' (NUM_REQ-1) rather
    // than at 2^SEL_W. The final probe lands on 'last' itself, so every index
    // is visited exactly once.
    function automatic logic [SEL_W:0] rr_next(
        input logic [MAX_REQ-1:0] req,
        input logic [SEL_W-1:0]   last,
        input logic [SEL_W-1:0]   top
    );
        logic [SEL_W:0]   res;
        logic [SEL_W-1:0] idx;
        res = '0;
        idx = last;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k <= int'(top)) begin
                idx = (idx == top) ? '0 : idx + 1'b1;
                if (!res[SEL_W] && req[idx]) res = {1'b1, idx};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker.
//   req_i    : masked request vector
//   last_i   : index of the most recent winner
//   winner_o : first requester above last_i (wrapping modulo NUM_REQ)
//   found_o  : at least one requester is pending
module rr_pick #(
    parameter int NUM_REQ = 31,
    parameter int SEL_W   = 5
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [SEL_W-1:0]   last_i,
    output logic [SEL_W-1:0]   winner_o,
    output logic               found_o
);
    import mux_sched_pkg::*;

    localparam int PW = mux_sched_pkg::SEL_W;

    logic [MAX_REQ-1:0] req_ext;
    logic [PW:0]        res;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req_i;
        res = rr_next(req_ext, PW'(last_i), PW'(NUM_REQ - 1));
    end

    assign winner_o = SEL_W'(res[PW-1:0]);
    assign found_o  = res[PW];

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler sharing one NUM_REQ-input mux among NUM_REQ requesters.
// Grants a requester, drives its index on sel for one cycle, captures mux_data
// and presents it downstream with a valid/ready handshake.
//   CLK, RST_N         : clock, asynchronous active-low reset
//   en                 : allows new grants (in-flight transfers always finish)
//   req                : level requests
//   sel / mux_data     : mux select out, combinational mux output in
//   out_valid/ready    : downstream handshake, out_data / out_id payload
//   ack                : one-hot pulse in the handshake cycle
//   busy               : FSM not idle
module mux_rr_scheduler #(
    parameter int               NUM_REQ  = 31,
    parameter int               SEL_W    = 5,
    parameter int               DATA_W   = 2,
    parameter logic [SEL_W-1:0] PARK_SEL = 5'd31
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [SEL_W-1:0]   sel,
    input  logic [DATA_W-1:0]  mux_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [SEL_W-1:0]   out_id,
    output logic [NUM_REQ-1:0] ack,
    output logic               busy
);
    import mux_sched_pkg::*;

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    grant_q, grant_d;
    logic [SEL_W-1:0]    last_q, last_d;
    logic [DATA_W-1:0]   data_q, data_d;

    logic [NUM_REQ-1:0]  grant_oh;
    logic [NUM_REQ-1:0]  pick_req;
    logic [SEL_W-1:0]    pick_last;
    logic [SEL_W-1:0]    winner;
    logic                found;
    logic                in_valid;
    logic                hs;

    assign in_valid = (state_q == VALID);
    assign hs       = in_valid && out_ready;
    assign grant_oh = NUM_REQ'(1) << grant_q;

    // In VALID the current grant is about to become 'last', so search from it
    // and hide its own request to stop a hog from winning twice in a row.
    assign pick_req  = in_valid ? (req & ~grant_oh) : req;
    assign pick_last = in_valid ? grant_q : last_q;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .SEL_W   (SEL_W)
    ) u_pick (
        .req_i    (pick_req),
        .last_i   (pick_last),
        .winner_o (winner),
        .found_o  (found)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (en && found) begin
                    grant_d = winner;
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                data_d  = mux_data;
                state_d = VALID;
            end
            VALID: begin
                if (out_ready) begin
                    last_d = grant_q;
                    if (en && found) begin
                        grant_d = winner;
                        state_d = SAMPLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= SEL_W'(NUM_REQ - 1);
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    assign sel       = (state_q == SAMPLE) ? grant_q : PARK_SEL;
    assign out_valid = in_valid;
    assign out_data  = data_q;
    assign out_id    = grant_q;
    assign ack       = hs ? grant_oh : '0;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mux_rr_scheduler.sv
module tb_mux_rr_scheduler;
    localparam int NR = 31;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          en;
    logic [NR-1:0] req;
    logic [4:0]    sel;
    logic [1:0]    mux_data;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_data;
    logic [4:0]    out_id;
    logic [NR-1:0] ack;
    logic          busy;

    logic [1:0]    tbl [0:NR-1];
    int            total = 0;
    int            bad   = 0;
    int            m_last;

    always #5 CLK = ~CLK;

    // The shared mux: input i carries tbl[i]; out-of-range selects read 0.
    assign mux_data = (sel < 5'(NR)) ? tbl[sel] : 2'b00;

    mux_rr_scheduler dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .en        (en),
        .req       (req),
        .sel       (sel),
        .mux_data  (mux_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .ack       (ack),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: scan positions last+1, last+2, ... modulo NR.
    function automatic int pick(input logic [NR-1:0] r, input int last);
        for (int k = 1; k <= NR; k++) begin
            int i;
            i = (last + k) % NR;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] oh(input int i);
        logic [NR-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Starting idle at a falling edge, hold req=r and run nx transfers with a
    // random stall of smin..smax cycles each; en drops at the last handshake.
    task automatic chain(input logic [NR-1:0] r, input int nx, input int smin, input int smax);
        int w, nw, stall;
        logic [1:0] expd;
        req = r; en = 1'b1; out_ready = 1'b0;
        w = pick(r, m_last);
        for (int t = 0; t < nx; t++) begin
            @(negedge CLK);
            chk("sample_sel", sel, w);
            chk("sample_busy", busy, 1);
            chk("sample_nvalid", out_valid, 0);
            chk("sample_noack", ack, 0);
            expd = tbl[w];
            @(negedge CLK);
            stall = $urandom_range(smax, smin);
            for (int s = 0; s <= stall; s++) begin
                if (s > 0) @(negedge CLK);
                out_ready = (s == stall);
                if (s == stall && t == nx - 1) en = 1'b0;
                #1;
                chk("valid", out_valid, 1);
                chk("out_id", out_id, w);
                chk("out_data", out_data, expd);
                chk("sel_park", sel, 31);
                chk("ack", ack, (s == stall) ? oh(w) : '0);
                if (s < stall) tbl[w] = ~tbl[w];
            end
            m_last = w;
            if (t < nx - 1) begin
                nw = pick(r & ~oh(w), w);
                if (nw < 0) begin
                    @(negedge CLK);
                    chk("gap_busy", busy, 0);
                    chk("gap_sel", sel, 31);
                    chk("gap_noack", ack, 0);
                    nw = pick(r, m_last);
                end
                w = nw;
            end
        end
        @(negedge CLK);
        chk("end_busy", busy, 0);
        chk("end_nvalid", out_valid, 0);
        chk("end_noack", ack, 0);
        req = '0; en = 1'b1; out_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: run exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] r;
        logic [1:0]    d4;
        for (int i = 0; i < NR; i++) tbl[i] = 2'($urandom);
        RST_N = 1'b0; en = 1'b0; req = '0; out_ready = 1'b0;

        // Reset values, before any clock edge
        #3;
        chk("rst_sel", sel, 31);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_id", out_id, 0);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        m_last = NR - 1;

        // Single request on input 7 carrying 2'b10
        tbl[7] = 2'b10;
        chain(oh(7), 1, 0, 0);

        // Wrap-around: make 29 the last winner, then request {30, 0, 5}
        chain(oh(29), 1, 0, 0);
        chain(oh(30) | oh(0) | oh(5), 3, 0, 0);

        // Backpressure: 4 stalled cycles per transfer with mux input toggling
        chain(oh(12) | oh(20), 2, 4, 4);

        // Hog masking, back-to-back at one transfer per 2 cycles
        chain(oh(3) | oh(9), 4, 0, 0);

        // Enable and retraction during SAMPLE of requester 4
        req = oh(4); en = 1'b1; out_ready = 1'b0;
        @(negedge CLK);
        chk("ret_sel", sel, 4);
        d4 = tbl[4];
        en = 1'b0; req = '0;
        @(negedge CLK);
        chk("ret_valid", out_valid, 1);
        chk("ret_id", out_id, 4);
        chk("ret_data", out_data, d4);
        out_ready = 1'b1;
        #1;
        chk("ret_ack", ack, oh(4));
        m_last = 4;
        @(negedge CLK);
        chk("ret_idle", busy, 0);
        req = oh(4);
        repeat (3) begin
            @(negedge CLK);
            chk("dis_busy", busy, 0);
            chk("dis_sel", sel, 31);
            chk("dis_noack", ack, 0);
        end
        req = '0; en = 1'b1; out_ready = 1'b0;

        // Randomised request patterns, stall lengths and mux contents
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < NR; i++) tbl[i] = 2'($urandom);
            r = NR'($urandom);
            if (r == '0) r = oh(n % NR);
            chain(r, $urandom_range(4, 1), 0, 2);
        end

        // Reset in the middle of VALID drops the transfer without ack
        req = oh(10); en = 1'b1; out_ready = 1'b0;
        @(negedge CLK);
        chk("mid_sel", sel, 10);
        @(negedge CLK);
        chk("mid_valid", out_valid, 1);
        #1;
        RST_N = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_sel", sel, 31);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_id", out_id, 0);
        chk("mid_rst_data", out_data, 0);
        out_ready = 1'b1;
        #1;
        chk("mid_rst_noack", ack, 0);
        req = '0; out_ready = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        m_last = NR - 1;
        chain('1, 5, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
